keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Parametrised push-button front end. Synchronises and debounces NUM_KEYS raw inputs.
//   Emits one-cycle press pulses per key and serialises them into a queued key-code
//   stream, one code per cycle. Sits between the pb[] pads and the mode and note
//   control logic, and replaces the single-key rising-edge detector.
// PARAMETERS
//   NUM_KEYS        16  number of button channels (>=2)
//   SYNC_STAGES     2   synchroniser flops per channel (>=2)
//   DEBOUNCE_CYCLES 4   consecutive cycles a synced level must persist (>=1)
//   REPEAT_DELAY    20  cycles from emission to first auto-repeat (KEYPAD_REPEAT_EN only)
//   REPEAT_PERIOD   8   cycles between later auto-repeats (KEYPAD_REPEAT_EN only)
// PORTS
//   clk        in   1                     system clock, rising edge
//   n_rst      in   1                     reset, synchronous, active-low
//   pb         in   NUM_KEYS              raw asynchronous button levels, 1 = pressed
//   stable     out  NUM_KEYS              debounced levels
//   press      out  NUM_KEYS              1-cycle pulse per debounced 0->1 transition
//   key_valid  out  1                     key_code holds an emitted key this cycle
//   key_code   out  $clog2(NUM_KEYS)      index of emitted key
//   overrun    out  1                     1-cycle pulse: press hit a key already pending
// BEHAVIOUR
//   - Reset (n_rst==0 at a clk edge): sync chains, counters, stable, press, pending,
//     key_valid, key_code, overrun and the repeat state all go to 0. Reset overrides
//     everything in the same edge.
//   - Sync: pb[i] shifts through SYNC_STAGES flops. s[i] is the last stage.
//   - Debounce, per key:
//     - s[i]==stable[i]: cnt[i]<=0.
//     - Otherwise cnt[i]++.
//     - Once cnt[i]==DEBOUNCE_CYCLES-1 with s[i]!=stable[i]: stable[i]<=s[i] and cnt[i]<=0.
//     - Counter width is $clog2(DEBOUNCE_CYCLES+1). It never wraps.
//   - Latency: pb[i] steady from edge 0 gives stable[i] updated at edge
//     SYNC_STAGES+DEBOUNCE_CYCLES. Any bounce shorter than DEBOUNCE_CYCLES restarts the count.
//   - press[i] is registered. It is 1 exactly in the first cycle stable[i] reads 1.
//     Release generates no pulse.
//   - Pending queue: a NUM_KEYS-bit mask.
//     - Each cycle the lowest set bit j is cleared, with key_valid<=1 and key_code<=j
//       visible the next cycle.
//     - Empty mask: key_valid<=0. key_code holds its last value.
//     - Press to key_valid latency is 1 cycle when the queue is empty.
//     - Simultaneous presses drain lowest index first, one per cycle.
//     - Same-cycle set and clear of a bit: set wins, and the key is emitted again later.
//     - press[i] while pending[i] is already 1 and not being cleared: overrun<=1 for one
//       cycle, no duplicate queued.
//   - Reset while a key is held: stable=0 after reset, so the held key is re-detected as
//     a fresh press after SYNC_STAGES+DEBOUNCE_CYCLES cycles.
// CONFIGURATION
//   KEYPAD_REPEAT_EN defined:
//     - One shared repeat timer tracks the most recently emitted key r.
//     - REPEAT_DELAY cycles after r is emitted, while stable[r]==1, pending[r] is set.
//       It is then set again every REPEAT_PERIOD cycles.
//     - A repeat set into a busy pending[r] raises overrun.
//     - stable[r]==0 idles the timer. Emitting a different key retargets and restarts it.
//     - Reset idles it.
//   KEYPAD_REPEAT_EN undefined: no timer logic. REPEAT_DELAY and REPEAT_PERIOD are
//   ignored. Holding a key emits exactly one code.
// TESTING (NUM_KEYS=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//   1. pb[3]=1 at edge 0 and held
//      -> stable[3] and press[3] rise at edge 6, press[3] high for 1 cycle.
//      -> key_valid=1 with key_code=3 after edge 7, for 1 cycle.
//   2. pb[3] bounces 1,0,1,0 (2 cycles each), then held 1
//      -> exactly one press[3]: stable[3] rises 6 edges after the final rise, one code=3.
//   3. pb[5] and pb[2] rise together
//      -> press on the same cycle; key_code=2 next cycle, then key_code=5 the cycle after.
//   4. Six keys pressed together, and one of them re-pressed while still queued
//      -> codes drain in ascending order, 6 consecutive valid cycles.
//      -> the re-press pulses overrun once and adds no extra code.
//   5. pb[7] held, n_rst=0 for 1 cycle at edge 10
//      -> all outputs 0 at edge 11; stable[7] re-rises at edge 17; code=7 emitted again.
//   6. KEYPAD_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=8, pb[1] held, first code at cycle t
//      -> code=1 also at t+20, t+28, t+36.
//      -> release stops repeats within SYNC_STAGES+DEBOUNCE_CYCLES cycles.
//      -> with the macro undefined, only the code at t.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: synchronises and debounces NUM_KEYS push-buttons, emits a
// one-cycle press pulse per debounced rising edge and serialises the presses
// into a key-code stream, lowest index first, one code per cycle.
// Optional build macro KEYPAD_REPEAT_EN adds a shared auto-repeat timer for the
// most recently emitted key.
module keypad_scanner #(
   parameter int NUM_KEYS        = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 20,
   parameter int REPEAT_PERIOD   = 8
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic [NUM_KEYS-1:0]         pb,
   output logic [NUM_KEYS-1:0]         stable,
   output logic [NUM_KEYS-1:0]         press,
   output logic                        key_valid,
   output logic [$clog2(NUM_KEYS)-1:0] key_code,
   output logic                        overrun
);

   localparam int KW = $clog2(NUM_KEYS);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [NUM_KEYS-1:0][SYNC_STAGES-1:0] sync_q;
   logic [NUM_KEYS-1:0][CW-1:0]          cnt_q;
   logic [NUM_KEYS-1:0]                  s;
   logic [NUM_KEYS-1:0]                  flip;
   logic [NUM_KEYS-1:0]                  pending;
   logic [NUM_KEYS-1:0]                  set_vec;
   logic [NUM_KEYS-1:0]                  rep_vec;
   logic [NUM_KEYS-1:0]                  req;
   logic [NUM_KEYS-1:0]                  grant;
   logic [NUM_KEYS-1:0]                  pending_nxt;
   logic                                 gnt_any;
   logic [KW-1:0]                        gnt_idx;
   logic                                 ovr_nxt;

   // Synchroniser chains: pb enters at bit 0, s is the last stage.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         sync_q <= '0;
      end else begin
         for (int i = 0; i < NUM_KEYS; i++)
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pb[i]};
      end
   end

   // Synced level and the per-key "debounce window complete" condition.
   always_comb begin
      s    = '0;
      flip = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         s[i]    = sync_q[i][SYNC_STAGES-1];
         flip[i] = (s[i] != stable[i]) && (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1));
      end
   end

   // Debounce counters; press fires in the same edge stable rises.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         cnt_q  <= '0;
         stable <= '0;
         press  <= '0;
      end else begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            press[i] <= flip[i] & s[i];
            if (s[i] == stable[i]) begin
               cnt_q[i] <= '0;
            end else if (flip[i]) begin
               stable[i] <= s[i];
               cnt_q[i]  <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // Queue arbitration: new presses bypass the mask so an idle queue emits
   // one cycle after press; a set landing on a bit being cleared keeps it.
   always_comb begin
      set_vec = press | rep_vec;
      req     = pending | set_vec;
      gnt_any = 1'b0;
      gnt_idx = '0;
      grant   = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt_any = 1'b1;
            gnt_idx = KW'(i);
         end
      end
      if (gnt_any)
         grant[gnt_idx] = 1'b1;
      pending_nxt = (pending & ~grant) | (set_vec & ~(grant & ~pending));
      ovr_nxt     = |(set_vec & pending & ~grant);
   end

   // Pending mask and emitted-code registers.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         pending   <= '0;
         key_valid <= 1'b0;
         key_code  <= '0;
         overrun   <= 1'b0;
      end else begin
         pending   <= pending_nxt;
         key_valid <= gnt_any;
         overrun   <= ovr_nxt;
         if (gnt_any)
            key_code <= gnt_idx;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   logic [KW-1:0] rep_key;
   logic [RW-1:0] rep_cnt;
   logic          rep_act;
   logic          rep_first;
   logic          rep_fire;

   // Repeat request: first after REPEAT_DELAY, then every REPEAT_PERIOD.
   always_comb begin
      rep_vec  = '0;
      rep_fire = rep_act && stable[rep_key] &&
                 (rep_first ? (rep_cnt == RW'(REPEAT_DELAY - 1))
                            : (rep_cnt == RW'(REPEAT_PERIOD - 1)));
      if (rep_fire)
         rep_vec[rep_key] = 1'b1;
   end

   // Repeat timer: retargets on emission of a new key, idles on release;
   // re-emitting the tracked key (its own repeat) keeps the cadence.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         rep_key   <= '0;
         rep_cnt   <= '0;
         rep_act   <= 1'b0;
         rep_first <= 1'b0;
      end else if (gnt_any && (!rep_act || gnt_idx != rep_key)) begin
         rep_key   <= gnt_idx;
         rep_cnt   <= '0;
         rep_act   <= 1'b1;
         rep_first <= 1'b1;
      end else if (rep_act && !stable[rep_key]) begin
         rep_act <= 1'b0;
      end else if (rep_act) begin
         if (rep_fire) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
         end else begin
            rep_cnt <= rep_cnt + RW'(1);
         end
      end
   end
`else
   // No auto-repeat: only debounced presses feed the queue.
   always_comb begin
      rep_vec = '0;
   end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: main instance at DEBOUNCE_CYCLES=4,
// a second instance at DEBOUNCE_CYCLES=1 so a key can be re-pressed while
// still queued behind lower keys.
module tb_keypad_scanner;
   logic        clk = 1'b0;
   logic        n_rst;
   logic [15:0] pb, stable, press;
   logic        key_valid, overrun;
   logic [3:0]  key_code;
   logic [15:0] pb_f, stable_f, press_f;
   logic        key_valid_f, overrun_f;
   logic [3:0]  key_code_f;
   int checks = 0;
   int failures = 0;

   keypad_scanner u_dut (
      .clk(clk), .n_rst(n_rst), .pb(pb), .stable(stable), .press(press),
      .key_valid(key_valid), .key_code(key_code), .overrun(overrun));

   keypad_scanner #(.DEBOUNCE_CYCLES(1)) u_fast (
      .clk(clk), .n_rst(n_rst), .pb(pb_f), .stable(stable_f), .press(press_f),
      .key_valid(key_valid_f), .key_code(key_code_f), .overrun(overrun_f));

   always #5 clk = ~clk;

   // Advance one edge and step clear of it before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      pb = '0;
      pb_f = '0;
      repeat (12) tick();
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      pb = 16'hffff;
      pb_f = 16'hffff;
      repeat (3) tick();
      checks++;
      if ({stable, press, key_valid, key_code, overrun} !== '0) begin
         failures++;
         $display("FAIL reset_main: got stable=%h press=%h v=%b code=%0d ovr=%b, want all 0",
                  stable, press, key_valid, key_code, overrun);
      end
      checks++;
      if ({stable_f, press_f, key_valid_f, key_code_f, overrun_f} !== '0) begin
         failures++;
         $display("FAIL reset_fast: got stable=%h press=%h v=%b code=%0d ovr=%b, want all 0",
                  stable_f, press_f, key_valid_f, key_code_f, overrun_f);
      end
      pb = '0;
      pb_f = '0;
      n_rst = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_single_press();
      int nv = 0;
      for (int k = 1; k <= 12; k++) begin
         if (k == 1) pb[3] = 1'b1;
         tick();
         if (key_valid) nv++;
         if (k == 5) begin
            checks++;
            if (stable !== 16'h0000) begin
               failures++; $display("FAIL single_stable_early: got %h want 0000", stable);
            end
         end
         if (k == 6) begin
            checks++;
            if (stable !== 16'h0008 || press !== 16'h0008 || key_valid !== 1'b0) begin
               failures++;
               $display("FAIL single_rise: got stable=%h press=%h v=%b want 0008 0008 0",
                        stable, press, key_valid);
            end
         end
         if (k == 7) begin
            checks++;
            if (press !== 16'h0000 || key_valid !== 1'b1 || key_code !== 4'd3) begin
               failures++;
               $display("FAIL single_emit: got press=%h v=%b code=%0d want 0000 1 3",
                        press, key_valid, key_code);
            end
         end
      end
      checks++;
      if (nv !== 1) begin
         failures++; $display("FAIL single_count: got %0d codes want 1", nv);
      end
      pb = '0;
      nv = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (key_valid || press != 0) nv++;
      end
      checks++;
      if (nv !== 0 || stable !== 16'h0000) begin
         failures++;
         $display("FAIL release_quiet: got events=%0d stable=%h want 0 0000", nv, stable);
      end
      settle();
   endtask

   task automatic test_bounce();
      int np = 0, pk = 0, nv = 0, vk = 0;
      logic [3:0] code = '0;
      for (int k = 1; k <= 25; k++) begin
         pb[3] = (k <= 8) ? (((k - 1) / 2) % 2 == 0) : 1'b1;
         tick();
         if (press[3]) begin np++; pk = k; end
         if (key_valid) begin nv++; vk = k; code = key_code; end
      end
      checks++;
      if (np !== 1 || pk !== 14) begin
         failures++; $display("FAIL bounce_press: got %0d pulses at edge %0d want 1 at 14", np, pk);
      end
      checks++;
      if (nv !== 1 || vk !== 15 || code !== 4'd3) begin
         failures++;
         $display("FAIL bounce_code: got %0d codes at %0d code=%0d want 1 at 15 code 3", nv, vk, code);
      end
      settle();
   endtask

   task automatic test_simultaneous();
      for (int k = 1; k <= 10; k++) begin
         if (k == 1) pb = 16'h0024;
         tick();
         if (k == 6) begin
            checks++;
            if (press !== 16'h0024) begin
               failures++; $display("FAIL simul_press: got %h want 0024", press);
            end
         end
         if (k == 7 || k == 8) begin
            checks++;
            if (key_valid !== 1'b1 || key_code !== ((k == 7) ? 4'd2 : 4'd5)) begin
               failures++;
               $display("FAIL simul_code_e%0d: got v=%b code=%0d want 1 %0d",
                        k, key_valid, key_code, (k == 7) ? 2 : 5);
            end
         end
         if (k == 9) begin
            checks++;
            if (key_valid !== 1'b0) begin
               failures++; $display("FAIL simul_drain: got v=%b want 0", key_valid);
            end
         end
      end
      settle();
   endtask

   task automatic test_overrun();
      int codes[$];
      int first_k = 0, last_k = 0, novr = 0, ovr_k = 0;
      int exp_codes[6] = '{0, 3, 6, 9, 12, 15};
      for (int k = 1; k <= 14; k++) begin
         if (k == 1) pb_f = 16'h9249;
         if (k == 2) pb_f[15] = 1'b0;
         if (k == 3) pb_f[15] = 1'b1;
         tick();
         if (key_valid_f) begin
            if (codes.size() == 0) first_k = k;
            last_k = k;
            codes.push_back(int'(key_code_f));
         end
         if (overrun_f) begin novr++; ovr_k = k; end
         if (k == 3) begin
            checks++;
            if (press_f !== 16'h9249) begin
               failures++; $display("FAIL ovr_press: got %h want 9249", press_f);
            end
         end
         if (k == 5) begin
            checks++;
            if (press_f !== 16'h8000) begin
               failures++; $display("FAIL ovr_repress: got %h want 8000", press_f);
            end
         end
      end
      checks++;
      if (codes.size() !== 6 || first_k !== 4 || last_k !== 9) begin
         failures++;
         $display("FAIL ovr_stream: got %0d codes edges %0d..%0d want 6 edges 4..9",
                  codes.size(), first_k, last_k);
      end
      for (int i = 0; i < codes.size() && i < 6; i++) begin
         checks++;
         if (codes[i] !== exp_codes[i]) begin
            failures++; $display("FAIL ovr_order_%0d: got %0d want %0d", i, codes[i], exp_codes[i]);
         end
      end
      checks++;
      if (novr !== 1 || ovr_k !== 6) begin
         failures++; $display("FAIL ovr_pulse: got %0d pulses at %0d want 1 at 6", novr, ovr_k);
      end
      settle();
   endtask

   task automatic test_reset_held();
      for (int k = 1; k <= 20; k++) begin
         if (k == 1) pb[7] = 1'b1;
         if (k == 10) n_rst = 1'b0;
         if (k == 11) n_rst = 1'b1;
         tick();
         if (k == 7) begin
            checks++;
            if (key_valid !== 1'b1 || key_code !== 4'd7) begin
               failures++; $display("FAIL held_first: got v=%b code=%0d want 1 7", key_valid, key_code);
            end
         end
         if (k == 10) begin
            checks++;
            if ({stable, press, key_valid, key_code, overrun} !== '0) begin
               failures++;
               $display("FAIL held_reset: got stable=%h press=%h v=%b code=%0d ovr=%b want all 0",
                        stable, press, key_valid, key_code, overrun);
            end
         end
         if (k == 15) begin
            checks++;
            if (stable !== 16'h0000) begin
               failures++; $display("FAIL held_early: got %h want 0000", stable);
            end
         end
         if (k == 16) begin
            checks++;
            if (stable !== 16'h0080 || press !== 16'h0080) begin
               failures++; $display("FAIL held_rerise: got stable=%h press=%h want 0080 0080", stable, press);
            end
         end
         if (k == 17) begin
            checks++;
            if (key_valid !== 1'b1 || key_code !== 4'd7) begin
               failures++; $display("FAIL held_reemit: got v=%b code=%0d want 1 7", key_valid, key_code);
            end
         end
      end
      settle();
   endtask

   task automatic test_repeat();
      int vk[$];
      int exp_k[$];
      int bad_code = 0;
`ifdef KEYPAD_REPEAT_EN
      exp_k = '{7, 27, 35, 43};
`else
      exp_k = '{7};
`endif
      for (int k = 1; k <= 62; k++) begin
         if (k == 1) pb[1] = 1'b1;
         if (k == 45) pb[1] = 1'b0;
         tick();
         if (key_valid) begin
            vk.push_back(k);
            if (key_code != 4'd1) bad_code++;
         end
      end
      checks++;
      if (vk.size() !== exp_k.size() || bad_code !== 0) begin
         failures++;
         $display("FAIL repeat_count: got %0d codes (%0d not key 1) want %0d",
                  vk.size(), bad_code, exp_k.size());
      end
      for (int i = 0; i < vk.size() && i < exp_k.size(); i++) begin
         checks++;
         if (vk[i] !== exp_k[i]) begin
            failures++; $display("FAIL repeat_time_%0d: got edge %0d want %0d", i, vk[i], exp_k[i]);
         end
      end
      settle();
   endtask

   initial begin
      n_rst = 1'b0;
      pb = '0;
      pb_f = '0;
      test_reset();
      test_single_press();
      test_bounce();
      test_simultaneous();
      test_overrun();
      test_reset_held();
      test_repeat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
